// File: rtl/gcd_pkg.sv
// Shared types and helpers for the binary (Stein) GCD engine.
// Optional cycle counter in gcd_engine is enabled with GCD_CYCLE_COUNT_EN.
package gcd_pkg;

  // Controller states of the GCD engine
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REDUCE = 2'd2,
    DONE   = 2'd3
  } gcd_state_t;

  // Width of the common power-of-two counter k
  function automatic int gcd_k_width(input int width);
    return $clog2(width) + 1;
  endfunction

  // Upper bound on cycles from accept to result for a given operand width
  function automatic int GCD_MAX_LAT(input int width);
    return 4 * width + 2;
  endfunction

endpackage

// File: rtl/gcd_engine.sv
// Sequential binary (Stein) GCD core, one reduction step per clock.
// Operands arrive on a valid/ready port; the result is held on a
// valid/ready port until taken. All outputs are registered.
// Build option: define GCD_CYCLE_COUNT_EN to report the step count of the
// last computation on `cycles`; otherwise `cycles` is constant 0.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             busy,
  output logic [31:0]      cycles
);

  localparam int KW = gcd_k_width(WIDTH);
  localparam logic [KW-1:0] K_ONE = KW'(1);

  gcd_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             accept_s;

  // Next-state, datapath step and registered-output decode
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    k_d      = k_q;
    gcd_d    = gcd_q;
    accept_s = in_valid && in_ready_q;

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          a_d = in_a;
          b_d = in_b;
          k_d = '0;
          if ((in_a == '0) || (in_b == '0)) begin
            // GCD with a zero operand is the other operand (and 0 for 0,0)
            gcd_d   = in_a | in_b;
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        if (!a_q[0] && !b_q[0]) begin
          // Strip a common factor of two and remember it in k
          a_d = {1'b0, a_q[WIDTH-1:1]};
          b_d = {1'b0, b_q[WIDTH-1:1]};
          k_d = k_q + K_ONE;
        end else begin
          state_d = REDUCE;
        end
      end

      REDUCE: begin
        if (!a_q[0]) begin
          a_d = {1'b0, a_q[WIDTH-1:1]};
        end else if (!b_q[0]) begin
          b_d = {1'b0, b_q[WIDTH-1:1]};
        end else if (a_q == b_q) begin
          // Restore the common power of two; the true GCD always fits
          gcd_d   = a_q << k_q;
          state_d = DONE;
        end else if (a_q > b_q) begin
          a_d = a_q - b_q;
        end else begin
          b_d = b_q - a_q;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake outputs are registered copies of the next state
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      k_q         <= '0;
      gcd_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      k_q         <= k_d;
      gcd_q       <= gcd_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_gcd   = gcd_q;
  assign busy      = busy_q;

`ifdef GCD_CYCLE_COUNT_EN
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cycles_q, cycles_d;
  logic [31:0] cnt_inc_s;

  // Saturating step counter and latch of the final count on entering DONE
  always_comb begin
    cnt_d     = cnt_q;
    cycles_d  = cycles_q;
    cnt_inc_s = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : (cnt_q + 32'd1);
    if (state_q == IDLE) begin
      if (accept_s) begin
        cnt_d = 32'd0;
        if (state_d == DONE) begin
          // Zero-operand shortcut counts as a single step
          cycles_d = 32'd1;
        end else begin
          cycles_d = cycles_q;
        end
      end else begin
        cnt_d = cnt_q;
      end
    end else if ((state_q == SHIFT) || (state_q == REDUCE)) begin
      cnt_d = cnt_inc_s;
      if (state_d == DONE) begin
        cycles_d = cnt_inc_s;
      end else begin
        cycles_d = cycles_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter registers with synchronous reset
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cnt_q    <= 32'd0;
      cycles_q <= 32'd0;
    end else begin
      cnt_q    <= cnt_d;
      cycles_q <= cycles_d;
    end
  end

  assign cycles = cycles_q;
`else
  assign cycles = 32'd0;
`endif

endmodule

// File: tb/tb_gcd_engine.sv
// Self-checking bench for gcd_engine: directed table, multi-cycle corner
// sequences, and a random sweep against a Euclid reference model.
module tb_gcd_engine;
  import gcd_pkg::*;

  localparam int W       = 32;
  localparam int MAX_LAT = GCD_MAX_LAT(W);

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_gcd;
  logic          busy;
  logic [31:0]   cycles;

  int vec_cnt = 0;
  int err_cnt = 0;

  gcd_engine #(.WIDTH(W)) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gcd   (out_gcd),
    .busy      (busy),
    .cycles    (cycles)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Euclid by remainder: independent of the binary algorithm in the core
  function automatic logic [31:0] ref_gcd(input logic [31:0] a_in, input logic [31:0] b_in);
    logic [31:0] x, y, t;
    x = a_in;
    y = b_in;
    while (y != 32'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Expected step count: SHIFT/REDUCE cycles, or 1 for the zero shortcut
  function automatic logic [31:0] exp_cycles(input logic [31:0] a, input logic [31:0] b, input int lat);
`ifdef GCD_CYCLE_COUNT_EN
    if ((a == 32'd0) || (b == 32'd0)) return 32'd1;
    return 32'(lat);
`else
    return 32'd0;
`endif
  endfunction

  // Load operands and wait (bounded) for out_valid; lat = edges after accept
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] g, output int lat);
    int guard;
    guard = 0;
    @(negedge ACLK);
    while (!in_ready && guard < 50) begin
      @(negedge ACLK);
      guard++;
    end
    check("in_ready_before_load", {31'd0, in_ready}, 32'd1);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(posedge ACLK);
    #1;
    in_valid = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    lat = 0;
    while (!out_valid && lat <= MAX_LAT) begin
      @(posedge ACLK);
      #1;
      lat++;
    end
    check("result_within_bound", {31'd0, (out_valid && (lat <= MAX_LAT))}, 32'd1);
    g = out_gcd;
  endtask

  // Full operation with out_ready high: check result, cycles and handoff
  task automatic full_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    logic [31:0] g;
    int lat;
    run_op(a, b, g, lat);
    check(name, g, exp);
    check("cycles", cycles, exp_cycles(a, b, lat));
    if ((a == 32'd0) || (b == 32'd0)) begin
      check("zero_op_latency", 32'(lat), 32'd0);
    end
    @(posedge ACLK);
    #1;
    check("out_valid_drop", {31'd0, out_valid}, 32'd0);
    check("in_ready_return", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] g, ra, rb, f;
    int lat;

    tbl[0]  = '{32'd48, 32'd18, 32'd6};
    tbl[1]  = '{32'd0, 32'd7, 32'd7};
    tbl[2]  = '{32'd7, 32'd0, 32'd7};
    tbl[3]  = '{32'd0, 32'd0, 32'd0};
    tbl[4]  = '{32'h8000_0000, 32'h4000_0000, 32'h4000_0000};
    tbl[5]  = '{32'd35, 32'd21, 32'd7};
    tbl[6]  = '{32'd1, 32'd1, 32'd1};
    tbl[7]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[8]  = '{32'hFFFF_FFFF, 32'd1, 32'd1};
    tbl[9]  = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'd2};
    tbl[10] = '{32'd1024, 32'd768, 32'd256};
    tbl[11] = '{32'd17, 32'd289, 32'd17};

    ARESET    = 1'b1;
    in_valid  = 1'b0;
    in_a      = 32'd0;
    in_b      = 32'd0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_gcd", out_gcd, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cycles", cycles, 32'd0);
    @(negedge ACLK);
    ARESET = 1'b0;
    @(posedge ACLK);
    #1;
    check("in_ready_after_release", {31'd0, in_ready}, 32'd1);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      full_op("table_gcd", tbl[i].a, tbl[i].b, tbl[i].exp);
    end

    // Backpressure: result held while out_ready is low, extra load ignored
    out_ready = 1'b0;
    run_op(32'd35, 32'd21, g, lat);
    check("bp_gcd", g, 32'd7);
    for (int c = 0; c < 10; c++) begin
      @(negedge ACLK);
      if (c == 3) begin
        in_a     = 32'd99;
        in_b     = 32'd33;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge ACLK);
      #1;
      check("bp_out_gcd", out_gcd, 32'd7);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge ACLK);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge ACLK);
    #1;
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    check("bp_gcd_kept", out_gcd, 32'd7);
    check("bp_idle_not_busy", {31'd0, busy}, 32'd0);

    // Reset mid-operation
    @(negedge ACLK);
    in_a     = 32'd1000;
    in_b     = 32'd250;
    in_valid = 1'b1;
    @(posedge ACLK);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b1;
    @(posedge ACLK);
    #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_gcd", out_gcd, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_cycles", cycles, 32'd0);
    @(negedge ACLK);
    ARESET = 1'b0;
    full_op("after_reset_gcd", 32'd9, 32'd6, 32'd3);

    // Random sweep against the reference model
    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 3))
        0: begin
          ra = $urandom;
          rb = $urandom;
        end
        1: begin
          ra = $urandom & 32'h0000_FFFF;
          rb = $urandom & 32'h0000_FFFF;
        end
        2: begin
          f  = 32'($urandom_range(1, 255)) << $urandom_range(0, 12);
          ra = f * 32'($urandom_range(1, 4095));
          rb = f * 32'($urandom_range(1, 4095));
        end
        default: begin
          ra = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
          rb = ($urandom_range(0, 1) == 0) ? 32'd0 : ($urandom & 32'h00FF_FFFF);
        end
      endcase
      full_op("rand_gcd", ra, rb, ref_gcd(ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
